// File: rtl/npc_pkg.sv
// Shared decode types for the npc core: immediate-type codes, opcode
// constants and the XLEN-independent part of a decoded instruction bundle.
package npc_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_U    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_t;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;

  // Fixed-width decoded fields; the XLEN-wide pc and imm travel beside this
  // struct so that no bits go unused when XLEN is narrower than 64.
  typedef struct packed {
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    imm_t       imm_type;
    logic       illegal;
  } idu_bundle_t;

  localparam idu_bundle_t BUNDLE_RST = '{
    op:       7'd0,
    func3:    3'd0,
    func7:    7'd0,
    rd:       5'd0,
    rs1:      5'd0,
    rs2:      5'd0,
    imm_type: IMM_NONE,
    illegal:  1'b0
  };

endpackage

// File: rtl/idu_immgen.sv
// Combinational opcode classification and immediate generation.
// Picks the immediate format from the opcode, flags opcodes outside the
// legal set, and sign-extends the 32-bit immediate from inst[31] to XLEN.
module idu_immgen
  import npc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = (XLEN == 64)
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_t            imm_type,
  output logic            illegal
);

  logic signed [31:0] imm32_p0;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // Classify the opcode, then assemble the 32-bit immediate for that format.
  always_comb begin
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    imm32_p0 = '0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: imm_type = IMM_U;
      OPC_JAL:            imm_type = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM, OPC_FENCE:
                          imm_type = IMM_I;
      OPC_STORE:          imm_type = IMM_S;
      OPC_BRANCH:         imm_type = IMM_B;
      OPC_OP:             imm_type = IMM_NONE;
      OPC_OPIMM32: begin
        if (RV64_OPS) imm_type = IMM_I;
        else          illegal  = 1'b1;
      end
      OPC_OP32: begin
        if (!RV64_OPS) illegal = 1'b1;
      end
      default:            illegal  = 1'b1;
    endcase
    case (imm_type)
      IMM_I:   imm32_p0 = {{20{inst[31]}}, inst[31:20]};
      IMM_U:   imm32_p0 = {inst[31:12], 12'b0};
      IMM_S:   imm32_p0 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32_p0 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:   imm32_p0 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32_p0 = '0;
    endcase
  end

  assign imm = sext32(imm32_p0);

endmodule

// File: rtl/idu_pipe.sv
// Registered instruction decode stage with a two-entry skid buffer.
// M drives the outputs, S catches one extra instruction when downstream
// stalls; in_ready is simply !S.v so it never depends on out_ready.
// Optional: define IDU_PIPE_TRACE_EN for a simulation trace of every
// output transfer with a running 64-bit transfer count.
module idu_pipe
  import npc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_op,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal
);

  // ---- stage p0: decode at the input ----
  logic [XLEN-1:0] imm_p0;
  imm_t            imm_type_p0;
  logic            illegal_p0;
  idu_bundle_t     dec_p0;

  idu_immgen #(
    .XLEN     (XLEN),
    .RV64_OPS (RV64_OPS)
  ) u_immgen (
    .inst     (in_inst),
    .imm      (imm_p0),
    .imm_type (imm_type_p0),
    .illegal  (illegal_p0)
  );

  // Gather the fixed-width decoded fields for the incoming instruction.
  always_comb begin
    dec_p0          = BUNDLE_RST;
    dec_p0.op       = in_inst[6:0];
    dec_p0.func3    = in_inst[14:12];
    dec_p0.func7    = in_inst[31:25];
    dec_p0.rd       = in_inst[11:7];
    dec_p0.rs1      = in_inst[19:15];
    dec_p0.rs2      = in_inst[24:20];
    dec_p0.imm_type = imm_type_p0;
    dec_p0.illegal  = illegal_p0;
  end

  // ---- stage p1: main (M) and skid (S) registers ----
  idu_bundle_t     m_p1, s_p1;
  logic [XLEN-1:0] m_pc_p1, m_imm_p1, s_pc_p1, s_imm_p1;
  logic            m_vld_p1, s_vld_p1;
  logic            in_fire, out_fire, m_take;

  assign in_ready = ~s_vld_p1;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_vld_p1 & out_ready;
  // M can take a new entry when it is empty or its contents leave this cycle.
  assign m_take   = out_fire | ~m_vld_p1;

  // Occupancy: flush empties both entries; otherwise M refills from S first,
  // then from the input, and the input spills into S when M is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld_p1 <= 1'b0;
      s_vld_p1 <= 1'b0;
    end else if (flush) begin
      m_vld_p1 <= 1'b0;
      s_vld_p1 <= 1'b0;
    end else if (m_take) begin
      m_vld_p1 <= s_vld_p1 | in_fire;
      s_vld_p1 <= 1'b0;
    end else if (in_fire) begin
      s_vld_p1 <= 1'b1;
    end
  end

  // Payload movement matching the occupancy rules above; M only changes when
  // it is free, so outputs hold still while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p1     <= BUNDLE_RST;
      s_p1     <= BUNDLE_RST;
      m_pc_p1  <= '0;
      m_imm_p1 <= '0;
      s_pc_p1  <= '0;
      s_imm_p1 <= '0;
    end else if (!flush) begin
      if (m_take) begin
        if (s_vld_p1) begin
          m_p1     <= s_p1;
          m_pc_p1  <= s_pc_p1;
          m_imm_p1 <= s_imm_p1;
        end else if (in_fire) begin
          m_p1     <= dec_p0;
          m_pc_p1  <= in_pc;
          m_imm_p1 <= imm_p0;
        end
      end else if (in_fire) begin
        s_p1     <= dec_p0;
        s_pc_p1  <= in_pc;
        s_imm_p1 <= imm_p0;
      end
    end
  end

  assign out_valid    = m_vld_p1;
  assign out_pc       = m_pc_p1;
  assign out_op       = m_p1.op;
  assign out_func3    = m_p1.func3;
  assign out_func7    = m_p1.func7;
  assign out_rd       = m_p1.rd;
  assign out_rs1      = m_p1.rs1;
  assign out_rs2      = m_p1.rs2;
  assign out_imm      = m_imm_p1;
  assign out_imm_type = m_p1.imm_type;
  assign out_illegal  = m_p1.illegal;

`ifdef IDU_PIPE_TRACE_EN
  logic [63:0] trace_cnt;

  // Print each instruction as it leaves the stage, numbered from reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_cnt <= '0;
    end else if (out_fire) begin
      trace_cnt <= trace_cnt + 64'd1;
      $display("idu_pipe #%0d pc=%h op=%b f3=%h f7=%h rd=%0d rs1=%0d rs2=%0d imm=%h type=%s ill=%b",
               trace_cnt, m_pc_p1, m_p1.op, m_p1.func3, m_p1.func7, m_p1.rd,
               m_p1.rs1, m_p1.rs2, m_imm_p1, m_p1.imm_type.name(), m_p1.illegal);
    end
  end
`endif

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: XLEN=32 instance driven through directed and random
// handshake traffic against a queue-based reference, plus an XLEN=64
// instance for the RV64 opcodes and 64-bit sign extension.
module tb_idu_pipe;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // XLEN=32 instance
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [6:0]  out_op, out_func7;
  logic [2:0]  out_func3, out_imm_type;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_illegal;

  idu_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op(out_op), .out_func3(out_func3), .out_func7(out_func7),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_imm_type(out_imm_type), .out_illegal(out_illegal)
  );

  // XLEN=64 instance, always drained
  logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [31:0] w_in_inst;
  logic [63:0] w_in_pc, w_out_pc, w_out_imm;
  logic [6:0]  w_out_op, w_out_func7;
  logic [2:0]  w_out_func3, w_out_imm_type;
  logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
  logic        w_out_illegal;

  idu_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inst(w_in_inst), .in_pc(w_in_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc),
    .out_op(w_out_op), .out_func3(w_out_func3), .out_func7(w_out_func7),
    .out_rd(w_out_rd), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2),
    .out_imm(w_out_imm), .out_imm_type(w_out_imm_type), .out_illegal(w_out_illegal)
  );

  item_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode from the format tables, using plain arithmetic.
  function automatic void ref_dec(input logic [31:0] i, input int xlen,
                                  output logic [63:0] imm, output int ty, output bit ill);
    longint v;
    ill = 1'b0;
    ty  = 5;
    case (i[6:0])
      7'b0110111, 7'b0010111: ty = 1;
      7'b1101111:             ty = 4;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111: ty = 0;
      7'b0100011:             ty = 2;
      7'b1100011:             ty = 3;
      7'b0110011:             ty = 5;
      7'b0011011: begin if (xlen == 64) ty = 0; else ill = 1'b1; end
      7'b0111011: ill = (xlen != 64);
      default:    ill = 1'b1;
    endcase
    case (ty)
      0: v = longint'($signed(i)) >>> 20;
      1: v = longint'($signed(i & 32'hFFFF_F000));
      2: v = (longint'($signed(i)) >>> 25) * 32 + longint'(i[11:7]);
      3: v = 2048 * longint'(i[7]) + 32 * longint'(i[30:25]) + 2 * longint'(i[11:8])
             - 4096 * longint'(i[31]);
      4: v = 4096 * longint'(i[19:12]) + 2048 * longint'(i[20]) + 2 * longint'(i[30:21])
             - 1048576 * longint'(i[31]);
      default: v = 0;
    endcase
    imm = 64'(v);
    if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
  endfunction

  task automatic check_head32(input item_t it);
    logic [63:0] imm;
    int ty;
    bit ill;
    ref_dec(it.inst, 32, imm, ty, ill);
    chk("pc",    64'(out_pc),       it.pc & 64'hFFFF_FFFF);
    chk("op",    64'(out_op),       64'(it.inst[6:0]));
    chk("func3", 64'(out_func3),    64'(it.inst[14:12]));
    chk("func7", 64'(out_func7),    64'(it.inst[31:25]));
    chk("rd",    64'(out_rd),       64'(it.inst[11:7]));
    chk("rs1",   64'(out_rs1),      64'(it.inst[19:15]));
    chk("rs2",   64'(out_rs2),      64'(it.inst[24:20]));
    chk("imm",   64'(out_imm),      imm);
    chk("itype", 64'(out_imm_type), 64'(ty));
    chk("ill",   64'(out_illegal),  64'(ill));
  endtask

  // One cycle on the XLEN=32 instance: drive, check mid-cycle, advance model.
  task automatic step(input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    bit    in_acc, out_acc;
    item_t it;
    in_valid  = iv;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) check_head32(q[0]);
    in_acc  = iv && (q.size() < 2);
    out_acc = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (out_acc) void'(q.pop_front());
      if (in_acc) begin
        it.inst = inst;
        it.pc   = 64'(pc);
        q.push_back(it);
      end
    end
    #1;
  endtask

  // One instruction through the XLEN=64 instance.
  task automatic feed64(input logic [31:0] inst, input logic [63:0] pc);
    logic [63:0] imm;
    int ty;
    bit ill;
    chk("w_in_ready", 64'(w_in_ready), 64'd1);
    w_in_valid = 1'b1;
    w_in_inst  = inst;
    w_in_pc    = pc;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    ref_dec(inst, 64, imm, ty, ill);
    chk("w_out_valid", 64'(w_out_valid), 64'd1);
    chk("w_pc",        w_out_pc, pc);
    chk("w_rd",        64'(w_out_rd), 64'(inst[11:7]));
    chk("w_imm",       w_out_imm, imm);
    chk("w_itype",     64'(w_out_imm_type), 64'(ty));
    chk("w_ill",       64'(w_out_illegal), 64'(ill));
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [13] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0011011,
                           7'b0111011, 7'b1110011, 7'b0001111};

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    x = $urandom;
    if ($urandom_range(0, 4) != 0) x[6:0] = ops[$urandom_range(0, 12)];
    return x;
  endfunction

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_inst     = '0;
    in_pc       = '0;
    out_ready   = 1'b0;
    w_flush     = 1'b0;
    w_in_valid  = 1'b0;
    w_in_inst   = '0;
    w_in_pc     = '0;
    w_out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid),    64'd0);
    chk("rst_in_ready",  64'(in_ready),     64'd1);
    chk("rst_pc",        64'(out_pc),       64'd0);
    chk("rst_imm",       64'(out_imm),      64'd0);
    chk("rst_rd",        64'(out_rd),       64'd0);
    chk("rst_itype",     64'(out_imm_type), 64'd5);
    chk("rst_ill",       64'(out_illegal),  64'd0);
    chk("rst_w_valid",   64'(w_out_valid),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // XLEN=64: RV64 opcodes and 64-bit sign extension
    feed64(32'h0000001B, 64'h0000_0001_0000_0000);
    chk("addiw_ill",   64'(w_out_illegal),  64'd0);
    chk("addiw_imm",   w_out_imm,           64'd0);
    chk("addiw_itype", 64'(w_out_imm_type), 64'd0);
    feed64(32'h00000000, 64'h0000_0001_0000_0004);
    chk("zero_ill",    64'(w_out_illegal),  64'd1);
    chk("zero_imm",    w_out_imm,           64'd0);
    chk("zero_itype",  64'(w_out_imm_type), 64'd5);
    feed64(32'h800002B7, 64'hFFFF_0000_1234_5678);
    chk("lui64_imm",   w_out_imm,           64'hFFFF_FFFF_8000_0000);
    for (int k = 0; k < 30; k++) feed64(rand_inst(), {$urandom, $urandom});

    // addi x1,x0,-1
    step(1, 32'hFFF00093, 32'h0000_1000, 1, 0);
    chk("addi_valid", 64'(out_valid),    64'd1);
    chk("addi_rd",    64'(out_rd),       64'd1);
    chk("addi_rs1",   64'(out_rs1),      64'd0);
    chk("addi_imm",   64'(out_imm),      64'hFFFF_FFFF);
    chk("addi_itype", 64'(out_imm_type), 64'd0);
    chk("addi_ill",   64'(out_illegal),  64'd0);

    // back-to-back lui then beq
    step(1, 32'h123452B7, 32'h0000_1004, 1, 0);
    chk("lui_imm",   64'(out_imm),      64'h1234_5000);
    chk("lui_itype", 64'(out_imm_type), 64'd1);
    step(1, 32'hFE000EE3, 32'h0000_1008, 1, 0);
    chk("beq_valid", 64'(out_valid),    64'd1);
    chk("beq_imm",   64'(out_imm),      64'hFFFF_FFFC);
    chk("beq_itype", 64'(out_imm_type), 64'd3);
    step(0, 32'h0, 32'h0, 1, 0);

    // backpressure: three offered, two taken, then drain in order
    step(1, 32'h00500113, 32'h0000_2000, 0, 0);
    step(1, 32'h00A00193, 32'h0000_2004, 0, 0);
    step(1, 32'h00F00213, 32'h0000_2008, 0, 0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(1, 32'h00F00213, 32'h0000_2008, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // flush while FULL with a same-cycle input
    step(1, 32'h00100093, 32'h0000_3000, 0, 0);
    step(1, 32'h00200093, 32'h0000_3004, 0, 0);
    step(1, 32'h00300093, 32'h0000_3008, 0, 1);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // async reset while ONE
    step(1, 32'hFFF00093, 32'h0000_4000, 0, 0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid",    64'(out_valid),    64'd0);
    chk("arst_rd",       64'(out_rd),       64'd0);
    chk("arst_imm",      64'(out_imm),      64'd0);
    chk("arst_pc",       64'(out_pc),       64'd0);
    chk("arst_itype",    64'(out_imm_type), 64'd5);
    chk("arst_in_ready", 64'(in_ready),     64'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // random traffic
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end
    for (int k = 0; k < 4; k++) step(0, 32'h0, 32'h0, 1, 0);
    chk("end_empty", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
